// File: rtl/wb_dbg_arbiter.sv
// Two-master Wishbone arbiter (CPU m0, debug bridge m1) with whole-cycle grants,
// debug priority or round-robin, and a stall timeout that aborts hung slave accesses.
module wb_dbg_arbiter #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned PRIORITY_DBG   = 1
) (
  input  logic            clock,
  input  logic            FPGA_rst,
  input  logic            dbg_en,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_w,
  input  logic [DW/8-1:0] m0_sel,
  output logic [DW-1:0]   m0_dat_r,
  output logic            m0_ack,
  output logic            m0_err,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_w,
  input  logic [DW/8-1:0] m1_sel,
  output logic [DW-1:0]   m1_dat_r,
  output logic            m1_ack,
  output logic            m1_err,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  input  logic [DW-1:0]   s_dat_r,
  input  logic            s_ack,
  input  logic            s_err,
  output logic [1:0]      grant,
  output logic [7:0]      abort_count
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, OWN0, OWN1, ABORT, REJECT} state_t;

  state_t          state, state_nxt;
  logic            last_owner, last_owner_nxt;
  logic            abort_owner, abort_owner_nxt;
  logic            m1_block, m1_block_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [7:0]      abort_count_nxt;

  logic            req0, req1_raw, req1;
  logic            own1, owning;
  logic            own_cyc, own_stb, own_we;
  logic [AW-1:0]   own_adr;
  logic [DW-1:0]   own_dat_w;
  logic [DW/8-1:0] own_sel;
  logic            waiting, timeout, abort_cyc;

  assign req0     = m0_cyc & m0_stb;
  assign req1_raw = m1_cyc & m1_stb & ~m1_block;
  assign req1     = req1_raw & dbg_en;

  assign own1      = (state == OWN1);
  assign owning    = (state == OWN0) | (state == OWN1);
  assign own_cyc   = own1 ? m1_cyc   : m0_cyc;
  assign own_stb   = own1 ? m1_stb   : m0_stb;
  assign own_we    = own1 ? m1_we    : m0_we;
  assign own_adr   = own1 ? m1_adr   : m0_adr;
  assign own_dat_w = own1 ? m1_dat_w : m0_dat_w;
  assign own_sel   = own1 ? m1_sel   : m0_sel;

  // timer holds the number of stalled cycles already seen, so the abort fires
  // combinationally on the TIMEOUT_CYCLES-th stalled cycle itself
  assign waiting   = owning & own_cyc & own_stb & ~s_ack & ~s_err;
  assign timeout   = (TIMEOUT_CYCLES != 0) && waiting && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign abort_cyc = abort_owner ? m1_cyc : m0_cyc;

  // a rejected m1 stays ignored until it releases cyc
  assign m1_block_nxt = ((state == IDLE) && (state_nxt == REJECT)) | (m1_block & m1_cyc);

  always_comb begin
    state_nxt       = state;
    last_owner_nxt  = last_owner;
    abort_owner_nxt = abort_owner;
    timer_nxt       = '0;
    abort_count_nxt = abort_count;
    grant           = '0;
    s_cyc           = 1'b0;
    s_stb           = 1'b0;
    s_we            = 1'b0;
    s_adr           = '0;
    s_dat_w         = '0;
    s_sel           = '0;
    m0_ack          = 1'b0;
    m0_err          = 1'b0;
    m0_dat_r        = '0;
    m1_ack          = 1'b0;
    m1_err          = 1'b0;
    m1_dat_r        = '0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          if ((PRIORITY_DBG != 0) && dbg_en) state_nxt = OWN1;
          else                               state_nxt = last_owner ? OWN0 : OWN1;
        end else if (req0) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end else if (req1_raw) begin
          state_nxt = REJECT;
        end
      end
      OWN0, OWN1: begin
        grant   = own1 ? 2'b10 : 2'b01;
        s_cyc   = own_cyc & ~timeout;
        s_stb   = own_stb & ~timeout;
        s_we    = own_we;
        s_adr   = own_adr;
        s_dat_w = own_dat_w;
        s_sel   = own_sel;
        if (own1) begin
          m1_ack   = s_ack;
          m1_err   = s_err | timeout;
          m1_dat_r = s_dat_r;
        end else begin
          m0_ack   = s_ack;
          m0_err   = s_err | timeout;
          m0_dat_r = s_dat_r;
        end
        if (timeout) begin
          state_nxt       = ABORT;
          abort_owner_nxt = own1;
          if (abort_count != 8'hFF) abort_count_nxt = abort_count + 8'd1;
        end else if (!own_cyc) begin
          state_nxt      = IDLE;
          last_owner_nxt = own1;
        end else if (waiting) begin
          timer_nxt = timer + 1'b1;
        end
      end
      ABORT: begin
        if (!abort_cyc) begin
          state_nxt      = IDLE;
          last_owner_nxt = abort_owner;
        end
      end
      REJECT: begin
        m1_err    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (FPGA_rst) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      abort_owner <= 1'b0;
      m1_block    <= 1'b0;
      timer       <= '0;
      abort_count <= '0;
    end else begin
      state       <= state_nxt;
      last_owner  <= last_owner_nxt;
      abort_owner <= abort_owner_nxt;
      m1_block    <= m1_block_nxt;
      timer       <= timer_nxt;
      abort_count <= abort_count_nxt;
    end
  end

endmodule

// File: tb/tb_wb_dbg_arbiter.sv
// Bench for wb_dbg_arbiter: directed table, corner-case sequences and random traffic,
// checked against a cycle-level reference model of the arbitration rules.
module tb_wb_dbg_arbiter;

  localparam int TO = 8;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        FPGA_rst, dbg_en;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat_w, m1_adr, m1_dat_w, s_dat_r;
  logic [3:0]  m0_sel, m1_sel;
  logic        s_ack, s_err;

  logic [31:0] o_m0_dat_r [2];
  logic [31:0] o_m1_dat_r [2];
  logic [31:0] o_s_adr    [2];
  logic [31:0] o_s_dat_w  [2];
  logic [3:0]  o_s_sel    [2];
  logic        o_m0_ack [2], o_m0_err [2], o_m1_ack [2], o_m1_err [2];
  logic        o_s_cyc  [2], o_s_stb  [2], o_s_we   [2];
  logic [1:0]  o_grant  [2];
  logic [7:0]  o_abort  [2];

  // instance 0: debug priority, instance 1: pure round-robin; both share the stimulus
  for (genvar k = 0; k < 2; k++) begin : g_dut
    wb_dbg_arbiter #(
      .AW(32), .DW(32), .TIMEOUT_CYCLES(TO), .PRIORITY_DBG((k == 0) ? 1 : 0)
    ) dut (
      .clock(clock), .FPGA_rst(FPGA_rst), .dbg_en(dbg_en),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_dat_r(o_m0_dat_r[k]),
      .m0_ack(o_m0_ack[k]), .m0_err(o_m0_err[k]),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_dat_r(o_m1_dat_r[k]),
      .m1_ack(o_m1_ack[k]), .m1_err(o_m1_err[k]),
      .s_cyc(o_s_cyc[k]), .s_stb(o_s_stb[k]), .s_we(o_s_we[k]), .s_adr(o_s_adr[k]),
      .s_dat_w(o_s_dat_w[k]), .s_sel(o_s_sel[k]), .s_dat_r(s_dat_r),
      .s_ack(s_ack), .s_err(s_err), .grant(o_grant[k]), .abort_count(o_abort[k])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h, expected %0h (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  grant;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_w;
    logic [3:0]  s_sel;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_dat_r, m1_dat_r;
    logic [7:0]  abort_count;
  } outs_t;

  int    owner [2];   // -1 when nobody holds the bus
  bit    aborted [2], rejecting [2], blocked [2], tmo [2], stalled [2];
  int    last [2], waits [2], aborts [2];
  int    prio [2] = '{1, 0};
  outs_t e [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; aborted[k] = 0; rejecting[k] = 0; blocked[k] = 0;
      last[k] = 1; waits[k] = 0; aborts[k] = 0;
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      outs_t x;
      logic  c, s;
      x = '0;
      stalled[k] = 0;
      tmo[k] = 0;
      if (owner[k] >= 0 && !aborted[k]) begin
        c = (owner[k] == 1) ? m1_cyc : m0_cyc;
        s = (owner[k] == 1) ? m1_stb : m0_stb;
        stalled[k] = c && s && !s_ack && !s_err;
        tmo[k]     = stalled[k] && (waits[k] + 1 == TO);
        x.grant    = (owner[k] == 1) ? 2'b10 : 2'b01;
        x.s_cyc    = c && !tmo[k];
        x.s_stb    = s && !tmo[k];
        x.s_we     = (owner[k] == 1) ? m1_we    : m0_we;
        x.s_adr    = (owner[k] == 1) ? m1_adr   : m0_adr;
        x.s_dat_w  = (owner[k] == 1) ? m1_dat_w : m0_dat_w;
        x.s_sel    = (owner[k] == 1) ? m1_sel   : m0_sel;
        if (owner[k] == 1) begin
          x.m1_ack = s_ack; x.m1_err = s_err || tmo[k]; x.m1_dat_r = s_dat_r;
        end else begin
          x.m0_ack = s_ack; x.m0_err = s_err || tmo[k]; x.m0_dat_r = s_dat_r;
        end
      end else if (rejecting[k]) begin
        x.m1_err = 1'b1;
      end
      x.abort_count = aborts[k][7:0];
      e[k] = x;
      check("mdl_grant",    k, o_grant[k],    x.grant);
      check("mdl_s_cyc",    k, o_s_cyc[k],    x.s_cyc);
      check("mdl_s_stb",    k, o_s_stb[k],    x.s_stb);
      check("mdl_s_we",     k, o_s_we[k],     x.s_we);
      check("mdl_s_adr",    k, o_s_adr[k],    x.s_adr);
      check("mdl_s_dat_w",  k, o_s_dat_w[k],  x.s_dat_w);
      check("mdl_s_sel",    k, o_s_sel[k],    x.s_sel);
      check("mdl_m0_ack",   k, o_m0_ack[k],   x.m0_ack);
      check("mdl_m0_err",   k, o_m0_err[k],   x.m0_err);
      check("mdl_m0_dat_r", k, o_m0_dat_r[k], x.m0_dat_r);
      check("mdl_m1_ack",   k, o_m1_ack[k],   x.m1_ack);
      check("mdl_m1_err",   k, o_m1_err[k],   x.m1_err);
      check("mdl_m1_dat_r", k, o_m1_dat_r[k], x.m1_dat_r);
      check("mdl_abort",    k, o_abort[k],    x.abort_count);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit rej_now, r0, r1raw, r1;
      logic c;
      rej_now = 0;
      r0    = m0_cyc && m0_stb;
      r1raw = m1_cyc && m1_stb && !blocked[k];
      r1    = r1raw && dbg_en;
      c     = (owner[k] == 1) ? m1_cyc : m0_cyc;
      if (FPGA_rst) begin
        owner[k] = -1; aborted[k] = 0; rejecting[k] = 0; blocked[k] = 0;
        last[k] = 1; waits[k] = 0; aborts[k] = 0;
      end else begin
        if (owner[k] >= 0 && !aborted[k]) begin
          if (tmo[k]) begin
            aborted[k] = 1; waits[k] = 0;
            if (aborts[k] < 255) aborts[k]++;
          end else if (!c) begin
            last[k] = owner[k]; owner[k] = -1; waits[k] = 0;
          end else begin
            waits[k] = stalled[k] ? waits[k] + 1 : 0;
          end
        end else if (aborted[k]) begin
          if (!c) begin last[k] = owner[k]; owner[k] = -1; aborted[k] = 0; end
        end else if (rejecting[k]) begin
          rejecting[k] = 0;
        end else begin
          if (r0 && r1)  owner[k] = (prio[k] != 0 && dbg_en) ? 1 : ((last[k] == 1) ? 0 : 1);
          else if (r0)   owner[k] = 0;
          else if (r1)   owner[k] = 1;
          else if (r1raw) begin rejecting[k] = 1; rej_now = 1; end
        end
        if (rej_now)      blocked[k] = 1;
        else if (!m1_cyc) blocked[k] = 0;
      end
    end
  endtask

  task automatic settle();
    @(negedge clock);
    model_check();
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    FPGA_rst = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    m0_adr = '0; m0_dat_w = '0; m0_sel = '0; m1_adr = '0; m1_dat_w = '0; m1_sel = '0;
    s_dat_r = '0; s_ack = 0; s_err = 0;
  endtask

  // ---------------- directed table (checked on instance 0) ----------------
  typedef struct {
    bit          rst, dbg, c0, s0, c1, s1, we1, ack;
    logic [31:0] rdat;
    logic [1:0]  g;
    bit          scyc, a0, e0, a1, e1;
    logic [31:0] d0;
  } vec_t;

  vec_t tbl [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int found, gap;
    idle_inputs();
    dbg_en = 0;
    FPGA_rst = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;

    //                 rst dbg c0 s0 c1 s1 we ack rdat          g     scyc a0 e0 a1 e1 d0
    tbl.push_back(vec_t'{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 0, 0, 0, 0, 32'h0,        2'b01, 1, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 0, 0, 0, 0, 32'h0,        2'b01, 1, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 0, 0, 0, 1, 32'hDEADBEEF, 2'b01, 1, 1, 0, 0, 0, 32'hDEADBEEF});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        2'b01, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 1, 1, 1, 1, 1, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 1, 1, 1, 1, 1, 0, 0, 32'h0,        2'b10, 1, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 1, 1, 1, 1, 1, 0, 1, 32'hDEADBEEF, 2'b10, 1, 0, 0, 1, 0, 32'h0});
    tbl.push_back(vec_t'{0, 1, 1, 1, 0, 0, 0, 0, 32'h0,        2'b10, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 1, 1, 1, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 1, 1, 1, 0, 0, 0, 0, 32'h0,        2'b01, 1, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 1, 1, 1, 0, 0, 0, 1, 32'h12345678, 2'b01, 1, 1, 0, 0, 0, 32'h12345678});
    tbl.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        2'b01, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 0, 1, 32'h0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 0, 1, 32'h0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0});

    m1_adr = 32'h2600_0000;
    m1_dat_w = 32'hA5A5_0001;
    m1_sel = 4'hF;
    m0_adr = 32'h3000_0004;
    m0_sel = 4'hF;
    for (int i = 0; i < tbl.size(); i++) begin
      FPGA_rst = tbl[i].rst; dbg_en = tbl[i].dbg;
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1; m1_we = tbl[i].we1;
      s_ack = tbl[i].ack; s_dat_r = tbl[i].rdat; s_err = 0;
      settle();
      check("tbl_grant",    i, o_grant[0],    tbl[i].g);
      check("tbl_s_cyc",    i, o_s_cyc[0],    tbl[i].scyc);
      check("tbl_m0_ack",   i, o_m0_ack[0],   tbl[i].a0);
      check("tbl_m0_err",   i, o_m0_err[0],   tbl[i].e0);
      check("tbl_m1_ack",   i, o_m1_ack[0],   tbl[i].a1);
      check("tbl_m1_err",   i, o_m1_err[0],   tbl[i].e1);
      check("tbl_m0_dat_r", i, o_m0_dat_r[0], tbl[i].d0);
      advance();
    end

    // stall timeout: m0 never acknowledged
    idle_inputs();
    dbg_en = 0; m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0010;
    settle();
    check("to_idle_grant", 0, o_grant[0], 2'b00);
    advance();
    for (int i = 1; i <= TO; i++) begin
      settle();
      check("to_grant", i, o_grant[0], 2'b01);
      check("to_m0_err", i, o_m0_err[0], (i == TO) ? 1'b1 : 1'b0);
      check("to_s_cyc", i, o_s_cyc[0], (i == TO) ? 1'b0 : 1'b1);
      check("to_abort_pre", i, o_abort[0], 8'd0);
      advance();
    end
    s_ack = 1;
    settle();
    check("to_late_ack", 0, o_m0_ack[0], 1'b0);
    check("to_abort_grant", 0, o_grant[0], 2'b00);
    check("to_abort_s_cyc", 0, o_s_cyc[0], 1'b0);
    check("to_abort_count", 0, o_abort[0], 8'd1);
    advance();
    m0_cyc = 0; m0_stb = 0;
    cycle();
    settle();
    check("to_after_grant", 0, o_grant[0], 2'b00);
    check("to_after_count", 0, o_abort[0], 8'd1);
    advance();

    // reset in the middle of an m1 burst
    idle_inputs();
    dbg_en = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h2600_0040;
    found = 0;
    for (int w = 0; w < 4 && found == 0; w++) begin
      settle();
      if (o_grant[0] == 2'b10) found = 1;
      else advance();
    end
    check("rst_burst_granted", 0, o_grant[0], 2'b10);
    advance();
    s_ack = 1;
    cycle();
    cycle();
    FPGA_rst = 1;
    cycle();
    FPGA_rst = 0;
    settle();
    check("rst_grant",  0, o_grant[0],  2'b00);
    check("rst_s_cyc",  0, o_s_cyc[0],  1'b0);
    check("rst_m1_ack", 0, o_m1_ack[0], 1'b0);
    check("rst_m1_err", 0, o_m1_err[0], 1'b0);
    check("rst_m0_ack", 0, o_m0_ack[0], 1'b0);
    check("rst_abort",  0, o_abort[0],  8'd0);
    advance();

    // round-robin on instance 1 with both masters asking continuously
    idle_inputs();
    FPGA_rst = 1;
    cycle();
    FPGA_rst = 0;
    dbg_en = 1; s_ack = 1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int r = 0; r < 4; r++) begin
      found = 0;
      gap = 0;
      while (found == 0 && gap < 4) begin
        settle();
        if (o_grant[1] != 2'b00) found = 1;
        else begin advance(); gap++; end
      end
      check("rr_grant", r, o_grant[1], (r % 2 == 1) ? 2'b10 : 2'b01);
      check("rr_gap", r, gap, 1);
      advance();
      repeat (3) cycle();
      if (r % 2 == 1) begin m1_cyc = 0; m1_stb = 0; end
      else            begin m0_cyc = 0; m0_stb = 0; end
      cycle();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    end
    idle_inputs();
    repeat (2) cycle();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      FPGA_rst = ($urandom_range(399) == 0);
      if ($urandom_range(31) == 0) dbg_en = ~dbg_en;
      if ($urandom_range(7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(7) == 0) m1_cyc = ~m1_cyc;
      m0_stb = m0_cyc && ($urandom_range(3) != 0);
      m1_stb = m1_cyc && ($urandom_range(3) != 0);
      m0_we = $urandom_range(1); m1_we = $urandom_range(1);
      m0_adr = $urandom; m1_adr = $urandom; m0_dat_w = $urandom; m1_dat_w = $urandom;
      m0_sel = 4'($urandom); m1_sel = 4'($urandom); s_dat_r = $urandom;
      s_ack = ($urandom_range(4) == 0);
      s_err = ($urandom_range(15) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
